yuv2rgb_arb: RTL and testbench

Round-robin arbiter that shares one fixed-latency YCbCr-to-RGB converter between two pixel requesters (CH0, CH1). It accepts YCbCr beats on per-channel valid/ready inputs and issues one beat per cycle to the converter. A tag pipeline tracks which channel owns each in-flight beat. Results return into per-channel output FIFOs with valid/ready. Credit accounting guarantees no FIFO overflow, so the converter never needs to stall.

---
 rtl/yuv2rgb_arb.sv | 186 ++++++++++++++++++
 tb/tb_yuv2rgb_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv2rgb_arb.sv
// ============================================================================
// yuv2rgb_arb : two-channel round-robin front end for a shared YCbCr->RGB unit
// Rev 1.0 -- optional handshake counters cnt0/cnt1 under YUV2RGB_ARB_STATS_EN
// ============================================================================
`default_nettype none

module yuv2rgb_arb #(
  parameter int DSIZE  = 8,
  parameter int LAT    = 2,
  parameter int FDEPTH = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 s0_vld,
  output logic                 s0_rdy,
  input  logic [3*DSIZE-1:0]   s0_ycbcr,
  input  logic                 s1_vld,
  output logic                 s1_rdy,
  input  logic [3*DSIZE-1:0]   s1_ycbcr,
  output logic                 conv_vld,
  output logic [3*DSIZE-1:0]   conv_ycbcr,
  input  logic                 conv_rgb_vld,
  input  logic [3*DSIZE-1:0]   conv_rgb,
  output logic                 m0_vld,
  input  logic                 m0_rdy,
  output logic [3*DSIZE-1:0]   m0_rgb,
  output logic                 m1_vld,
  input  logic                 m1_rdy,
  output logic [3*DSIZE-1:0]   m1_rgb,
  output logic                 tag_err
`ifdef YUV2RGB_ARB_STATS_EN
  ,
  output logic [31:0]          cnt0,
  output logic [31:0]          cnt1
`endif
);

  localparam int PW = 3 * DSIZE;
  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);
  localparam int FW = $clog2(LAT + 2);
  localparam logic [CW:0]   C_DEPTH = (CW + 1)'(FDEPTH);
  localparam logic [FW-1:0] C_FLUSH = FW'(LAT + 1);

  logic [1:0]    w_vld;
  logic [1:0]    w_elig;
  logic [1:0]    w_req;
  logic [1:0]    w_grant;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_mrdy;
  logic [1:0]    w_mvld;
  logic [PW-1:0] w_head [2];

  logic          r_last;
  logic [LAT:0]  r_tvld;
  logic [LAT:0]  r_tch;
  logic [FW-1:0] r_flush;

  logic          w_tag_vld;
  logic          w_tag_ch;
  logic          w_res_vld;

  assign w_vld  = {s1_vld, s0_vld};
  assign w_mrdy = {m1_rdy, m0_rdy};
  assign w_req  = w_vld & w_elig;

  always_comb begin
    w_grant = 2'b00;
    case (w_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign s0_rdy = rst_n & w_grant[0];
  assign s1_rdy = rst_n & w_grant[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      conv_vld   <= 1'b0;
      conv_ycbcr <= '0;
      r_last     <= 1'b1;
      r_tvld     <= '0;
      r_tch      <= '0;
    end else begin
      conv_vld <= |w_grant;
      if (|w_grant) begin
        conv_ycbcr <= w_grant[1] ? s1_ycbcr : s0_ycbcr;
        r_last     <= w_grant[1];
      end
      r_tvld <= {r_tvld[LAT-1:0], |w_grant};
      r_tch  <= {r_tch[LAT-1:0], w_grant[1]};
    end
  end

  // Results from beats issued before a reset can still emerge from the converter
  // for up to LAT cycles after release; they are masked so they neither land nor flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_flush <= C_FLUSH;
    end else if (r_flush != '0) begin
      r_flush <= r_flush - FW'(1);
    end
  end

  assign w_tag_vld = r_tvld[LAT];
  assign w_tag_ch  = r_tch[LAT];
  assign w_res_vld = conv_rgb_vld & (r_flush == '0);
  assign w_push    = {w_res_vld & w_tag_vld & w_tag_ch, w_res_vld & w_tag_vld & ~w_tag_ch};
  assign w_pop     = w_mvld & w_mrdy;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (w_res_vld != w_tag_vld) begin
      tag_err <= 1'b1;
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < 2; gc++) begin : g_chan
      logic [CW-1:0] r_count;
      logic [CW-1:0] r_infl;
      logic [AW-1:0] r_wr;
      logic [AW-1:0] r_rd;
      logic [PW-1:0] r_mem [2**AW];

      // A pop in this cycle frees its slot before any new grant can land there,
      // which lets one channel stream at full rate through a LAT+2 deep loop.
      assign w_elig[gc] = ({1'b0, r_count} + {1'b0, r_infl}) <
                          (C_DEPTH + {{CW{1'b0}}, w_pop[gc]});
      assign w_mvld[gc] = (r_count != '0);
      assign w_head[gc] = r_mem[r_rd];

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
          r_infl  <= '0;
          r_wr    <= '0;
          r_rd    <= '0;
        end else begin
          if (w_push[gc]) r_wr <= r_wr + AW'(1);
          if (w_pop[gc])  r_rd <= r_rd + AW'(1);
          case ({w_push[gc], w_pop[gc]})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
          case ({w_grant[gc], w_push[gc]})
            2'b10:   r_infl <= r_infl + CW'(1);
            2'b01:   r_infl <= r_infl - CW'(1);
            default: r_infl <= r_infl;
          endcase
        end
      end

      always_ff @(posedge clock) begin
        if (w_push[gc]) r_mem[r_wr] <= conv_rgb;
      end
    end
  endgenerate

  assign m0_vld = w_mvld[0];
  assign m1_vld = w_mvld[1];
  assign m0_rgb = w_mvld[0] ? w_head[0] : '0;
  assign m1_rgb = w_mvld[1] ? w_head[1] : '0;

`ifdef YUV2RGB_ARB_STATS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + 32'(w_pop[0]);
      cnt1 <= cnt1 + 32'(w_pop[1]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_yuv2rgb_arb.sv
// ============================================================================
// tb_yuv2rgb_arb : scoreboard bench for yuv2rgb_arb with a LAT-deep XOR converter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_yuv2rgb_arb;

  localparam int DSIZE  = 8;
  localparam int LAT    = 2;
  localparam int FDEPTH = 4;
  localparam int PW     = 3 * DSIZE;
  localparam logic [PW-1:0] XMASK = 24'h5A_A5_3C;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          s0_vld = 1'b0, s1_vld = 1'b0;
  logic          s0_rdy, s1_rdy;
  logic [PW-1:0] s0_ycbcr = '0, s1_ycbcr = '0;
  logic          conv_vld;
  logic [PW-1:0] conv_ycbcr;
  logic          conv_rgb_vld;
  logic [PW-1:0] conv_rgb;
  logic          m0_vld, m1_vld;
  logic          m0_rdy = 1'b1, m1_rdy = 1'b1;
  logic [PW-1:0] m0_rgb, m1_rgb;
  logic          tag_err;
`ifdef YUV2RGB_ARB_STATS_EN
  logic [31:0]   cnt0, cnt1;
`endif

  always #5 clock = ~clock;

  yuv2rgb_arb #(.DSIZE(DSIZE), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clock(clock), .rst_n(rst_n),
    .s0_vld(s0_vld), .s0_rdy(s0_rdy), .s0_ycbcr(s0_ycbcr),
    .s1_vld(s1_vld), .s1_rdy(s1_rdy), .s1_ycbcr(s1_ycbcr),
    .conv_vld(conv_vld), .conv_ycbcr(conv_ycbcr),
    .conv_rgb_vld(conv_rgb_vld), .conv_rgb(conv_rgb),
    .m0_vld(m0_vld), .m0_rdy(m0_rdy), .m0_rgb(m0_rgb),
    .m1_vld(m1_vld), .m1_rdy(m1_rdy), .m1_rgb(m1_rgb),
    .tag_err(tag_err)
`ifdef YUV2RGB_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  // Converter model: fixed LAT pipeline, deliberately blind to rst_n.
  logic [LAT-1:0] cv_pipe = '0;
  logic [PW-1:0]  cd_pipe [LAT];
  logic           inj_vld = 1'b0;
  logic [PW-1:0]  inj_data = '0;

  always @(posedge clock) begin
    for (int i = LAT - 1; i > 0; i--) begin
      cv_pipe[i] <= cv_pipe[i-1];
      cd_pipe[i] <= cd_pipe[i-1];
    end
    cv_pipe[0] <= conv_vld;
    cd_pipe[0] <= conv_ycbcr ^ XMASK;
  end
  assign conv_rgb_vld = cv_pipe[LAT-1] | inj_vld;
  assign conv_rgb     = inj_vld ? inj_data : cd_pipe[LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Sources, scoreboard and bookkeeping
  logic [PW-1:0] src0[$], src1[$];
  logic [PW-1:0] exp0[$], exp1[$];
  int  gl[$];
  bit  hs0 = 0, hs1 = 0, rst_vld = 0;
  int  cyc = 0;
  int  n_acc0 = 0, n_acc1 = 0, n_pop0 = 0, n_pop1 = 0, n_stall0 = 0;
  int  tot_pop0 = 0, tot_pop1 = 0;
  int  first_acc0 = -1, first_m0 = -1, first_any = -1, last_any = -1;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (!rst_n) begin
      s0_vld = rst_vld;
      s1_vld = rst_vld;
    end else begin
      if (hs0 && src0.size() > 0) void'(src0.pop_front());
      if (hs1 && src1.size() > 0) void'(src1.pop_front());
      s0_vld   = (src0.size() > 0);
      s1_vld   = (src1.size() > 0);
      s0_ycbcr = s0_vld ? src0[0] : '0;
      s1_ycbcr = s1_vld ? src1[0] : '0;
    end
  end

  always @(negedge clock) begin
    if (!rst_n) begin
      exp0.delete();
      exp1.delete();
      hs0 = 0;
      hs1 = 0;
    end else begin
      hs0 = s0_vld & s0_rdy;
      hs1 = s1_vld & s1_rdy;
      if (m0_vld && first_m0 < 0) first_m0 = cyc;
      if (s0_vld && !s0_rdy) n_stall0++;
      if (m0_vld && m0_rdy) begin
        n_pop0++; tot_pop0++;
        if (exp0.size() == 0) check("m0_unexpected_output", 1, 0);
        else check("m0_data", {8'h00, m0_rgb}, {8'h00, exp0.pop_front()});
      end
      if (m1_vld && m1_rdy) begin
        n_pop1++; tot_pop1++;
        if (exp1.size() == 0) check("m1_unexpected_output", 1, 0);
        else check("m1_data", {8'h00, m1_rgb}, {8'h00, exp1.pop_front()});
      end
      if (hs0 && hs1) check("single_grant", 2, 1);
      if (hs0 || hs1) begin
        if (first_any < 0) first_any = cyc;
        last_any = cyc;
        gl.push_back(hs1 ? 1 : 0);
      end
      if (hs0) begin
        exp0.push_back(s0_ycbcr ^ XMASK);
        n_acc0++;
        if (first_acc0 < 0) first_acc0 = cyc;
        check("fifo0_credit_overflow", 32'(exp0.size() > FDEPTH), 0);
      end
      if (hs1) begin
        exp1.push_back(s1_ycbcr ^ XMASK);
        n_acc1++;
        check("fifo1_credit_overflow", 32'(exp1.size() > FDEPTH), 0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_stats();
    n_acc0 = 0; n_acc1 = 0; n_pop0 = 0; n_pop1 = 0; n_stall0 = 0;
    first_acc0 = -1; first_m0 = -1; first_any = -1; last_any = -1;
    gl.delete();
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k = 0;
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    check(nm, 32'(k < budget), 1);
  endtask

  task automatic wait_acc0(input string nm, input int target);
    int k = 0;
    while (n_acc0 < target && k < 50) begin
      step();
      k++;
    end
    check(nm, 32'(k < 50), 1);
  endtask

  logic [PW-1:0] vec0 [8] = '{24'h108080, 24'h2070A0, 24'h3C6090, 24'h4A5588,
                              24'h80807F, 24'hEB8080, 24'h00FF00, 24'hFF00FF};

  initial begin
    int bad;
    int same;
    int k;

    // Reset state, with both requesters valid while rst_n is low
    rst_vld = 1;
    repeat (3) step();
    check("rst_conv_vld", 32'(conv_vld), 0);
    check("rst_conv_ycbcr", 32'(conv_ycbcr), 0);
    check("rst_s_rdy", {30'b0, s1_rdy, s0_rdy}, 0);
    check("rst_m_vld", {30'b0, m1_vld, m0_vld}, 0);
    check("rst_m_rgb", 32'(m0_rgb | m1_rgb), 0);
    check("rst_tag_err", 32'(tag_err), 0);
    rst_vld = 0;
    step();
    rst_n = 1;

    // Idle after release
    bad = 0;
    repeat (10) begin
      step();
      if (conv_vld || m0_vld || m1_vld || tag_err) bad++;
    end
    check("idle_quiet_cycles", bad, 0);

    // First tie goes to CH0
    src0.push_back(24'hA0A0A0);
    src1.push_back(24'hB1B1B1);
    k = 0;
    while (!s0_vld && k < 5) begin step(); k++; end
    check("tie_s0_rdy", 32'(s0_rdy), 1);
    check("tie_s1_rdy", 32'(s1_rdy), 0);
    wait_drain("tie_drain", 40);

    // CH0 alone, 8 beats
    clear_stats();
    for (int i = 0; i < 8; i++) src0.push_back(vec0[i]);
    wait_drain("ch0_stream_drain", 60);
    check("ch0_latency", first_m0 - first_acc0, LAT + 2);
    check("ch0_stall_cycles", n_stall0, 0);
    check("ch0_pop_count", n_pop0, 8);

    // Both channels saturating
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      src0.push_back(24'h010000 * i + 24'h000011);
      src1.push_back(24'h000100 * i + 24'h220000);
    end
    wait_drain("dual_drain", 100);
    same = 0;
    for (int i = 1; i < gl.size(); i++) if (gl[i] == gl[i-1]) same++;
    check("rr_alternation_breaks", same, 0);
    check("dual_acc0", n_acc0, 16);
    check("dual_acc1", n_acc1, 16);
    check("conv_busy_span", last_any - first_any + 1, 32);

    // CH1 backpressured: exactly FDEPTH beats, CH0 keeps going
    clear_stats();
    m1_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      src0.push_back(24'h300000 + 24'(i));
      src1.push_back(24'h400000 + 24'(i * 3));
    end
    repeat (40) step();
    check("bp_ch1_accepts", n_acc1, FDEPTH);
    check("bp_s1_rdy_low", {30'b0, s1_vld, s1_rdy}, 2);
    check("bp_ch0_accepts", n_acc0, 16);
    check("bp_m1_vld", 32'(m1_vld), 1);
    m1_rdy = 1;
    wait_drain("bp_resume_drain", 100);
    check("bp_ch1_pops", n_pop1, 16);
    check("bp_ch0_pops", n_pop0, 16);

    // Untagged converter result
    step();
    inj_data = 24'hDEAD01;
    inj_vld  = 1;
    step();
    inj_vld  = 0;
    step();
    check("inj_tag_err", 32'(tag_err), 1);
    check("inj_fifos_empty", {30'b0, m1_vld, m0_vld}, 0);
    repeat (5) step();
    check("inj_tag_err_sticky", 32'(tag_err), 1);
`ifdef YUV2RGB_ARB_STATS_EN
    check("stats_cnt0", cnt0, tot_pop0);
    check("stats_cnt1", cnt1, tot_pop1);
`endif

    // Reset with results both queued and in flight
    clear_stats();
    m0_rdy = 0;
    src0.push_back(24'h111111);
    src0.push_back(24'h222222);
    wait_acc0("rst_pre_acc2", 2);
    repeat (6) step();
    check("rst_pre_m0_vld", 32'(m0_vld), 1);
    src0.push_back(24'h333333);
    src0.push_back(24'h444444);
    wait_acc0("rst_pre_acc4", 4);
    step();
    rst_n = 0;
    src0.delete();
    src1.delete();
    #1;
    check("async_rst_conv_vld", 32'(conv_vld), 0);
    check("async_rst_m0", {7'b0, m0_vld, m0_rgb}, 0);
    check("async_rst_tag_err", 32'(tag_err), 0);
    check("async_rst_s0_rdy", 32'(s0_rdy), 0);
`ifdef YUV2RGB_ARB_STATS_EN
    check("async_rst_cnt", cnt0 | cnt1, 0);
`endif
    step();
    rst_n  = 1;
    m0_rdy = 1;
    bad = 0;
    repeat (8) begin
      step();
      if (m0_vld || m1_vld || tag_err) bad++;
    end
    check("stray_results_ignored", bad, 0);

    // Normal traffic after reset
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      src0.push_back(24'h550000 + 24'(i));
      src1.push_back(24'h660000 + 24'(i));
    end
    wait_drain("post_rst_drain", 60);
    check("post_rst_pops0", n_pop0, 3);
    check("post_rst_pops1", n_pop1, 3);
    check("post_rst_tag_err", 32'(tag_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
